mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 138 +++++++++++++
 tb/tb_mul_div_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply/divide unit with architectural HI/LO registers (33-edge latency).
// Define MULDIV_FAST_MUL_EN to replace iterative MULT/MULTU with a single-cycle multiplier.
module mul_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic        is_div;
  logic        neg_a;
  logic        neg_b;
  logic        b_zero;
  logic [31:0] a_raw;
  logic [31:0] addend;
  logic [63:0] p;

  // Magnitudes of the incoming operands; signed ops are op[0]==0.
  logic        in_neg_a, in_neg_b;
  logic [31:0] in_mag_a, in_mag_b;
  assign in_neg_a = ~op[0] & opA[31];
  assign in_neg_b = ~op[0] & opB[31];
  assign in_mag_a = in_neg_a ? -opA : opA;
  assign in_mag_b = in_neg_b ? -opB : opB;

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_prod;
  assign fast_prod = {32'b0, in_mag_a} * {32'b0, in_mag_b};
`endif

  // Multiply keeps {partial, multiplier}; divide keeps {remainder, dividend/quotient}.
  logic [32:0] mul_sum;
  logic [32:0] div_trial;
  logic [63:0] mul_next;
  logic [63:0] div_next;
  assign mul_sum   = {1'b0, p[63:32]} + (p[0] ? {1'b0, addend} : 33'd0);
  assign mul_next  = {mul_sum, p[31:1]};
  assign div_trial = {p[63:31]} - {1'b0, addend};
  assign div_next  = div_trial[32] ? {p[62:0], 1'b0}
                                   : {div_trial[31:0], p[30:0], 1'b1};

  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;
  assign prod_fix = (neg_a ^ neg_b) ? -p : p;
  assign quo_fix  = (neg_a ^ neg_b) ? -p[31:0] : p[31:0];
  assign rem_fix  = neg_a ? -p[63:32] : p[63:32];

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 6'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      is_div <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      b_zero <= 1'b0;
      a_raw  <= 32'd0;
      addend <= 32'd0;
      p      <= 64'd0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              is_div <= op[1];
              neg_a  <= in_neg_a;
              neg_b  <= in_neg_b;
              b_zero <= (opB == 32'd0);
              a_raw  <= opA;
              addend <= op[1] ? in_mag_b : in_mag_a;
              cnt    <= 6'd0;
              busy   <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
              if (!op[1]) begin
                p     <= fast_prod;
                state <= FINISH;
              end else begin
                p     <= {32'd0, in_mag_a};
                state <= CALC;
              end
`else
              p     <= op[1] ? {32'd0, in_mag_a} : {32'd0, in_mag_b};
              state <= CALC;
`endif
            end else begin
              if (mthi) hi <= opA;
              if (mtlo) lo <= opA;
            end
          end
          CALC: begin
            p   <= is_div ? div_next : mul_next;
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) state <= FINISH;
          end
          FINISH: begin
            if (!is_div) begin
              {hi, lo} <= prod_fix;
            end else if (b_zero) begin
              hi <= a_raw;
              lo <= 32'hFFFF_FFFF;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random ops against an arithmetic model.
module tb_mul_div_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo, flush;
  logic [1:0]  op;
  logic [31:0] opA, opB;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  mul_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
    .mthi(mthi), .mtlo(mtlo), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, m;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: r = sa * sb;
      2'd1: r = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          m = sa % sb;
          r = {m[31:0], q[31:0]};
        end
      end
      default: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
    endcase
    return r;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int n;
    exp = ref_model(o, a, b);
    start = 1'b1; op = o; opA = a; opB = b;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("latency", n, o[1] ? DIV_LAT : MUL_LAT);
    check("hi", hi, exp[63:32]);
    check("lo", lo, exp[31:0]);
    tick();
    check("done_cleared", {busy, done}, 2'b00);
  endtask

  initial begin
    int n, d0;
    logic [31:0] ra, rb;
    logic [1:0]  ro;
    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
    op = 2'd0; opA = 32'd0; opB = 32'd0;
    tick(); tick();
    reset = 1'b0;
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy_done", {busy, done}, 2'b00);

    // Directed corner cases.
    run_op(2'd0, 32'hFFFF_FFFE, 32'd3);
    check("mult_neg2x3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'd3, 32'd7, 32'd0);
    check("divu_by0", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(2'd2, 32'hFFFF_FFF0, 32'd0);
    run_op(2'd2, 32'd7, 32'hFFFF_FFFE);

    // Random operations, roughly one in eight with a zero divisor/multiplier.
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'hFF;
      run_op(ro, ra, rb);
    end

    // mthi/mtlo, both in one cycle.
    mthi = 1'b1; mtlo = 1'b1; opA = 32'hCAFE_F00D;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    check("mthi_mtlo_both", {hi, lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});

    // Start beats mthi; a later start while busy is ignored.
    start = 1'b1; mthi = 1'b1; op = 2'd2; opA = 32'd100; opB = 32'd7;
    tick();
    start = 1'b0; mthi = 1'b0;
    check("start_beats_mthi", hi, 32'hCAFE_F00D);
    d0 = done_cnt;
    n = 0;
    for (int k = 1; k < 10; k++) begin tick(); n++; end
    start = 1'b1; mthi = 1'b1; mtlo = 1'b1; op = 2'd1; opA = 32'd5; opB = 32'd5;
    tick(); n++;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    check("mthi_ignored_busy", hi, 32'hCAFE_F00D);
    while (done !== 1'b1 && n < 40) begin tick(); n++; end
    check("busy_start_latency", n, DIV_LAT);
    check("busy_start_result", {hi, lo}, {32'd2, 32'd14});
    for (int k = 0; k < 40; k++) tick();
    check("busy_start_one_done", done_cnt - d0, 1);
    check("busy_start_idle", busy, 0);

    // Flush at cycle 5 of a DIV.
    mthi = 1'b1; opA = 32'hAAAA_5555; tick(); mthi = 1'b0;
    mtlo = 1'b1; opA = 32'h1357_9BDF; tick(); mtlo = 1'b0;
    start = 1'b1; op = 2'd2; opA = 32'd1000; opB = 32'd3;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    d0 = done_cnt;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", busy, 0);
    for (int k = 0; k < 40; k++) tick();
    check("flush_no_done", done_cnt - d0, 0);
    check("flush_hilo", {hi, lo}, {32'hAAAA_5555, 32'h1357_9BDF});

    // Flush outranks start in IDLE.
    flush = 1'b1; start = 1'b1; op = 2'd3; opA = 32'd9; opB = 32'd2;
    tick();
    flush = 1'b0; start = 1'b0;
    check("flush_beats_start", busy, 0);

    // Reset at cycle 20 of a MULT, then mthi.
    start = 1'b1; op = 2'd0; opA = 32'd3; opB = 32'd5;
    tick();
    start = 1'b0;
    for (int k = 0; k < 19; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    d0 = done_cnt;
    check("midop_reset_hilo", {hi, lo}, 64'd0);
    check("midop_reset_busy_done", {busy, done}, 2'b00);
    for (int k = 0; k < 40; k++) tick();
    check("midop_reset_no_done", done_cnt - d0, 0);
    mthi = 1'b1; opA = 32'h0000_1234;
    tick();
    mthi = 1'b0;
    check("mthi_after_reset", hi, 32'h0000_1234);
    check("lo_after_mthi", lo, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
